// File: rtl/bcd4_scan_ctrl.sv
// rtl/bcd4_scan_ctrl.sv - four-digit BCD run/pause/clear counter with multiplexed digit scan
//
// Purpose: cascades four 0..9 digit counters under an IDLE/RUN/PAUSE state
// machine and time-multiplexes the digits onto a one-hot select plus BCD value
// for a seven-segment display decoder.
//
// Optional feature: define BCD4_BLANK_EN for leading-zero blanking of DIGSEL.
//
// Ports:
//   CLK     in   rising-edge clock
//   RST     in   asynchronous active-high reset
//   START   in   request RUN (from IDLE or PAUSE)
//   STOP    in   request PAUSE (from RUN)
//   CLR     in   clear counts, return to IDLE (highest priority)
//   INC     in   count strobe, honoured while in RUN
//   CNT     out  packed digits, [3:0] ones .. [15:12] thousands
//   OV      out  one-cycle pulse on the 9999 -> 0000 wrap
//   RUN     out  high while in RUN
//   DIGSEL  out  one-hot display digit select
//   DIGVAL  out  BCD value of the selected digit
module bcd4_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLR,
  input  logic        INC,
  output logic [15:0] CNT,
  output logic        OV,
  output logic        RUN,
  output logic [3:0]  DIGSEL,
  output logic [3:0]  DIGVAL
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_TERM = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digsel_q, digsel_d;
  logic [3:0]    digval_q, digval_d;
  logic          count_en;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic, priority CLR > STOP > START
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (START) state_d = S_RUN;
        S_RUN:   if (STOP)  state_d = S_PAUSE;
        S_PAUSE: if (START) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: RUN is registered from the next state so it changes on the
  // same edge that samples START/STOP/CLR.
  always_comb begin
    run_d = (state_d == S_RUN);
  end

  // Counting is gated by the current state, so START+INC in IDLE does not count
  // while STOP+INC in RUN does.
  assign count_en = (state_q == S_RUN) && INC;

  // Carry resolves combinationally through all four digits in one cycle.
  always_comb begin
    logic carry;
    cnt_d = cnt_q;
    carry = count_en;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        cnt_d[4*k +: 4] = (cnt_q[4*k +: 4] == 4'd9) ? 4'd0 : cnt_q[4*k +: 4] + 4'd1;
      end
      carry = carry && (cnt_q[4*k +: 4] == 4'd9);
    end
    // Carry out of the thousands digit is exactly the 9999 -> 0000 wrap.
    ov_d = carry;
    if (CLR) begin
      cnt_d = '0;
      ov_d  = 1'b0;
    end
  end

  // Scan divider and digit index run in every state.
  always_comb begin
    if (div_q == DIV_TERM) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DW'(1);
      idx_d = idx_q;
    end
  end

  // Select and value follow the index being loaded, so both change on the
  // divider wrap edge; the value is taken from the digit registers and thus
  // trails CNT by one cycle.
  always_comb begin
    digval_d = cnt_q[{idx_d, 2'b00} +: 4];
    digsel_d = 4'b0001 << idx_d;
`ifdef BCD4_BLANK_EN
    begin
      logic [3:0] upper_zero;
      // upper_zero[k]: digits k..3 are all zero
      upper_zero[3] = (cnt_q[15:12] == 4'd0);
      upper_zero[2] = upper_zero[3] && (cnt_q[11:8] == 4'd0);
      upper_zero[1] = upper_zero[2] && (cnt_q[7:4] == 4'd0);
      upper_zero[0] = upper_zero[1] && (cnt_q[3:0] == 4'd0);
      if ((idx_d != 2'd0) && upper_zero[idx_d]) begin
        digsel_d = 4'b0000;
      end
    end
`else
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      div_q    <= '0;
      idx_q    <= 2'd0;
      digsel_q <= 4'b0001;
      digval_q <= 4'h0;
    end else begin
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      digsel_q <= digsel_d;
      digval_q <= digval_d;
    end
  end

  assign CNT    = cnt_q;
  assign OV     = ov_q;
  assign RUN    = run_q;
  assign DIGSEL = digsel_q;
  assign DIGVAL = digval_q;

endmodule
